servant_mem_arbiter: RTL and testbench
======================================

# servant_mem_arbiter

Registered two-master Wishbone classic arbiter that shares the servant RAM slave between the SERV CPU master (m0) and a debug/firmware-load master (m1). It replaces direct CPU-to-RAM wiring inside the servant SoC so that a bench or debug transactor can read and write memory while the core runs. Arbitration is round-robin, and a grant is held until the slave acknowledges. A per-grant watchdog terminates hung cycles with an error.

## Interface
Parameters:
- `AW`, 32, address width of all ports.
- `TIMEOUT`, 15, maximum number of grant cycles without `s_ack` before `err` is asserted. 0 disables the watchdog.

Ports:
- `wb_clk` in 1: single clock, rising edge.
- `wb_rst_n` in 1: reset, asynchronous, active-low.
- `m0_adr` in AW, `m0_dat` in 32, `m0_sel` in 4, `m0_we` in 1, `m0_cyc` in 1: CPU master request.
- `m0_rdt` out 32, `m0_ack` out 1, `m0_err` out 1: CPU master response.
- `m1_adr` / `m1_dat` / `m1_sel` / `m1_we` / `m1_cyc` / `m1_rdt` / `m1_ack` / `m1_err`: debug master, same widths and meanings as m0.
- `s_adr` out AW, `s_dat` out 32, `s_sel` out 4, `s_we` out 1, `s_cyc` out 1: RAM slave request.
- `s_rdt` in 32, `s_ack` in 1: RAM slave response.

## Operation
- States: IDLE, GNT0, GNT1. Reset state is IDLE. The `last` register resets to 1, so m0 wins the first tie.
- IDLE transitions:
  - Only `m0_cyc` → GNT0. Only `m1_cyc` → GNT1.
  - Both asserted → grant the master not equal to `last`.
  - Neither → stay in IDLE.
- On entering GNTx, `last` := x.
- In GNTx:
  - `s_cyc = mx_cyc`. `s_adr`/`s_dat`/`s_sel`/`s_we` carry mx's values. `mx_ack = s_ack`.
  - The other master's ack and err are 0.
- In IDLE: `s_cyc`=0 and `s_adr`/`s_dat`/`s_sel`/`s_we` = 0.
- `s_rdt` is broadcast to both `m0_rdt` and `m1_rdt` at all times.
- GNTx exits to IDLE on any of:
  - `s_ack`=1 (normal completion).
  - `mx_cyc`=0 (master abort). No ack or err is issued.
  - Watchdog expiry.
- Watchdog:
  - Counter width is clog2(TIMEOUT+1). It clears on entering GNTx and increments each GNTx cycle without `s_ack`.
  - When the count equals TIMEOUT and `s_ack`=0, `mx_err`=1 for that single cycle, `s_cyc` is forced to 0, and the next state is IDLE.
  - `s_ack` in the same cycle wins: ack is given, err is not.
- `s_ack` arriving in IDLE, or while `s_cyc`=0, is ignored and not forwarded.
- Reset asserted mid-grant: the state machine goes to IDLE immediately (asynchronously) and `s_cyc` drops. The in-flight transfer is lost, with no ack or err.

## Timing
- Outputs during reset: `s_cyc`, `m0_ack`, `m1_ack`, `m0_err`, `m1_err` = 0; `s_adr`/`s_dat`/`s_sel`/`s_we` = 0.
- Request sampled in IDLE at edge N → `s_cyc` high in cycle N+1 (one cycle of arbitration latency).
- `s_ack` → `mx_ack` is combinational, zero cycles.
- A completed transfer returns to IDLE; the next grant's `s_cyc` is high two cycles after the ack cycle.
  - This gives exactly one dead `s_cyc`=0 cycle between back-to-back grants, which the servant RAM requires to deassert its registered ack.
- With a one-cycle-ack RAM: 3 cycles per transfer, and continuous dual requests alternate m0, m1, m0, …
- Masters must hold their request signals stable from `cyc` assertion until ack or err (Wishbone classic).

## Structure
- `servant_arb_pkg`: state enum (IDLE, GNT0, GNT1), master index constants M_CPU=0 and M_DBG=1, and a watchdog width function.
- One natural sub-module: `servant_arb_wdog`, the clearable saturating counter with an `expired` output, parameterised by TIMEOUT.
- Everything else is a single always_ff for state, `last` and the watchdog enable, plus combinational routing.

## Test plan
- Single access: m0 read at 0x100 with the RAM returning 0xDEADBEEF → `s_cyc` high one cycle after `m0_cyc`; `m0_ack` and `m0_rdt`=0xDEADBEEF in the same cycle as `s_ack`; `m1_ack` stays 0.
- Tie after reset: both `cyc` raised in the same cycle → m0 is granted first, then m1. Held continuously for 8 transfers, grants alternate 0,1,0,1 with one idle cycle between each.
- Debug write during CPU fetch: m1 writes 0x12345678 with `sel`=4'b0011 while m0 holds `cyc` → `s_dat`/`s_sel` carry m1's values only during GNT1; the m0 transfer completes afterwards.
- Watchdog: with TIMEOUT=15 and the slave never acking → `m0_err` pulses exactly in the 16th grant cycle; `s_cyc` is 0 in that cycle; m1 is granted next. With `s_ack` in that same cycle → ack is given and err is not.
- Abort: `m1_cyc` dropped in its second grant cycle → `s_cyc` drops the same cycle; no ack or err; a pending m0 is granted on the following edge.
- Reset mid-grant: `wb_rst_n` pulled low asynchronously during GNT0 → `s_cyc` and all acks go to 0 before the next edge; after release, a tie grants m0.

Source files
------------

// File: rtl/servant_arb_pkg.sv
// Shared types and constants for the servant RAM arbiter: FSM states,
// master indices and the watchdog counter width.
package servant_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    // A disabled watchdog (timeout 0) still gets a 1-bit counter so the port stays legal.
    function automatic int wdog_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/servant_arb_wdog.sv
// Clearable saturating grant-cycle counter; o_expired flags that the current
// grant has run TIMEOUT cycles without an acknowledge.
module servant_arb_wdog
    import servant_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int             W     = wdog_w(TIMEOUT);
    localparam logic [W-1:0]   LIMIT = W'(TIMEOUT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && r_cnt != LIMIT) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expired = (TIMEOUT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/servant_mem_arbiter.sv
// Round-robin two-master Wishbone classic arbiter in front of the servant RAM.
// A grant is held until ack, master abort or watchdog expiry, then returns to IDLE.
module servant_mem_arbiter
    import servant_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic [AW-1:0] m0_adr,
    input  logic [31:0]   m0_dat,
    input  logic [3:0]    m0_sel,
    input  logic          m0_we,
    input  logic          m0_cyc,
    output logic [31:0]   m0_rdt,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic [AW-1:0] m1_adr,
    input  logic [31:0]   m1_dat,
    input  logic [3:0]    m1_sel,
    input  logic          m1_we,
    input  logic          m1_cyc,
    output logic [31:0]   m1_rdt,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [AW-1:0] s_adr,
    output logic [31:0]   s_dat,
    output logic [3:0]    s_sel,
    output logic          s_we,
    output logic          s_cyc,
    input  logic [31:0]   s_rdt,
    input  logic          s_ack
);

    state_t r_state;
    logic   r_last;

    logic w_gnt;
    logic w_sel_m1;
    logic w_cyc;
    logic w_expired;
    logic w_timeout;
    logic w_done;
    logic w_err;

    assign w_gnt     = (r_state != IDLE);
    assign w_sel_m1  = (r_state == GNT1);
    assign w_cyc     = w_sel_m1 ? m1_cyc : m0_cyc;
    // An ack landing on the expiry cycle still completes the transfer normally.
    assign w_timeout = w_gnt && w_expired && !s_ack;
    assign w_done    = w_gnt && w_cyc && s_ack;
    assign w_err     = w_gnt && w_cyc && w_timeout;

    servant_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .i_clk     (wb_clk),
        .i_rst_n   (wb_rst_n),
        .i_clr     (!w_gnt),
        .i_en      (w_gnt && !s_ack),
        .o_expired (w_expired)
    );

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state <= IDLE;
            r_last  <= M_DBG;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_cyc && (!m1_cyc || r_last == M_DBG)) begin
                        r_state <= GNT0;
                        r_last  <= M_CPU;
                    end else if (m1_cyc) begin
                        r_state <= GNT1;
                        r_last  <= M_DBG;
                    end
                end
                default: begin
                    if (!w_cyc || s_ack || w_expired) r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_cyc  = w_gnt && w_cyc && !w_timeout;
    assign s_adr  = !w_gnt ? '0 : (w_sel_m1 ? m1_adr : m0_adr);
    assign s_dat  = !w_gnt ? '0 : (w_sel_m1 ? m1_dat : m0_dat);
    assign s_sel  = !w_gnt ? '0 : (w_sel_m1 ? m1_sel : m0_sel);
    assign s_we   = w_gnt && (w_sel_m1 ? m1_we : m0_we);

    assign m0_ack = w_done && !w_sel_m1;
    assign m1_ack = w_done && w_sel_m1;
    assign m0_err = w_err && !w_sel_m1;
    assign m1_err = w_err && w_sel_m1;
    assign m0_rdt = s_rdt;
    assign m1_rdt = s_rdt;

endmodule

// File: tb/tb_servant_mem_arbiter.sv
// Bench for servant_mem_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all cross-checked against a grant-level model.
module tb_servant_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b1;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_cyc [2];
    logic [31:0] m0_rdt, m1_rdt, s_adr, s_dat, s_rdt;
    logic        m0_ack, m0_err, m1_ack, m1_err, s_we, s_cyc, s_ack;
    logic [3:0]  s_sel;

    servant_mem_arbiter #(.AW(32), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .m0_adr(m_adr[0]), .m0_dat(m_dat[0]), .m0_sel(m_sel[0]), .m0_we(m_we[0]), .m0_cyc(m_cyc[0]),
        .m0_rdt(m0_rdt), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_adr(m_adr[1]), .m1_dat(m_dat[1]), .m1_sel(m_sel[1]), .m1_we(m_we[1]), .m1_cyc(m_cyc[1]),
        .m1_rdt(m1_rdt), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc),
        .s_rdt(s_rdt), .s_ack(s_ack)
    );

    always #5 wb_clk = ~wb_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // master transactors
    int          req_left [2] = '{0, 0};
    bit          abort    [2] = '{0, 0};
    bit          use_fix  [2] = '{0, 0};
    logic [31:0] fx_adr   [2];
    logic [31:0] fx_dat   [2];
    logic [3:0]  fx_sel   [2];
    logic        fx_we    [2];
    bit          done_seen[2] = '{0, 0};
    bit          rnd = 0;

    task automatic new_req(input int i);
        m_cyc[i] = 1'b1;
        if (use_fix[i]) begin
            m_adr[i] = fx_adr[i]; m_dat[i] = fx_dat[i]; m_sel[i] = fx_sel[i]; m_we[i] = fx_we[i];
        end else begin
            m_adr[i] = $urandom; m_dat[i] = $urandom;
            m_sel[i] = 4'($urandom_range(0, 15)); m_we[i] = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_adr[i] = 0; m_dat[i] = 0; m_sel[i] = 0; m_we[i] = 0;
        end
        forever begin
            @(posedge wb_clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (!wb_rst_n) begin
                    m_cyc[i] = 0; req_left[i] = 0; abort[i] = 0;
                end else if (m_cyc[i] && done_seen[i]) begin
                    if (req_left[i] > 0) req_left[i]--;
                    if (req_left[i] > 0 && !(rnd && $urandom_range(0, 3) == 0)) new_req(i);
                    else m_cyc[i] = 0;
                end else if (m_cyc[i] && (abort[i] || (rnd && $urandom_range(0, 60) == 0))) begin
                    m_cyc[i] = 0; abort[i] = 0;
                end else if (!m_cyc[i] && req_left[i] > 0 && !(rnd && $urandom_range(0, 2) == 0)) begin
                    new_req(i);
                end
            end
        end
    end

    // slave: 0 one-cycle RAM, 1 never acks, 2/3 random acks, 4 acks on 16th cycle, 5 always acks
    int          smode = 1;
    logic [31:0] ram_rdt = 32'h0;
    bit          cyc_seen = 0;
    int          run = 0;

    initial begin
        s_ack = 0; s_rdt = 0;
        forever begin
            @(posedge wb_clk); #1;
            case (smode)
                0: begin s_ack = cyc_seen && !s_ack; s_rdt = rnd ? $urandom : ram_rdt; end
                2: begin s_ack = ($urandom_range(0, 2) == 0); s_rdt = $urandom; end
                3: begin s_ack = ($urandom_range(0, 24) == 0); s_rdt = $urandom; end
                4: s_ack = (run == TIMEOUT);
                5: s_ack = 1'b1;
                default: s_ack = 1'b0;
            endcase
        end
    end

    // grant-level reference model, checker and monitor
    int          own = -1, age = 0, last = 1, ncyc = 0;
    int          ack_log[$], ack_t[$];
    logic [31:0] ack_dat[$];
    logic [3:0]  ack_sel[$];
    logic        ack_we[$];
    int          ack_n[2] = '{0, 0};
    int          err_n[2] = '{0, 0};
    logic [4:0]  ectl;
    logic [36:0] ereq;
    logic [31:0] edat;
    bit          tmo;

    always @(negedge wb_clk) begin
        ectl = '0; ereq = '0; edat = '0;
        if (wb_rst_n && own >= 0) begin
            tmo = (TIMEOUT != 0) && (age == TIMEOUT) && !s_ack;
            ectl[4]       = m_cyc[own] && !tmo;
            ectl[3 - own] = m_cyc[own] && s_ack;
            ectl[1 - own] = m_cyc[own] && tmo;
            ereq = {m_adr[own], m_we[own], m_sel[own]};
            edat = m_dat[own];
        end
        chk("ctl", {s_cyc, m0_ack, m1_ack, m0_err, m1_err}, ectl);
        chk("req", {s_adr, s_we, s_sel}, ereq);
        chk("wdat", s_dat, edat);
        chk("rdt", {m0_rdt, m1_rdt}, {s_rdt, s_rdt});

        ncyc++;
        done_seen[0] = m0_ack || m0_err;
        done_seen[1] = m1_ack || m1_err;
        if (m0_ack || m1_ack) begin
            ack_log.push_back(m1_ack ? 1 : 0); ack_t.push_back(ncyc);
            ack_dat.push_back(s_dat); ack_sel.push_back(s_sel); ack_we.push_back(s_we);
        end
        if (m0_ack) ack_n[0]++;
        if (m1_ack) ack_n[1]++;
        if (m0_err) err_n[0]++;
        if (m1_err) err_n[1]++;
        cyc_seen = s_cyc;
        run = s_cyc ? run + 1 : 0;

        if (!wb_rst_n) begin
            own = -1; last = 1; age = 0;
        end else if (own < 0) begin
            if (m_cyc[0] && m_cyc[1]) own = 1 - last;
            else if (m_cyc[0])        own = 0;
            else if (m_cyc[1])        own = 1;
            if (own >= 0) begin last = own; age = 0; end
        end else if (!m_cyc[own] || s_ack || ((TIMEOUT != 0) && age == TIMEOUT)) begin
            own = -1;
        end else begin
            age++;
        end
    end

    task automatic step();
        @(negedge wb_clk); #2;
    endtask

    task automatic clr_logs();
        ack_log.delete(); ack_t.delete(); ack_dat.delete(); ack_sel.delete(); ack_we.delete();
    endtask

    task automatic do_reset();
        step(); wb_rst_n = 0;
        repeat (2) step();
        wb_rst_n = 1;
    endtask

    task automatic wait_scyc(input string nm);
        int k = 0;
        do begin step(); k++; end while (!s_cyc && k < 8);
        chk(nm, s_cyc, 1);
    endtask

    task automatic wait_acks(input int n, input int lim, input string nm);
        int k = 0;
        while (ack_log.size() < n && k < lim) begin step(); k++; end
        chk(nm, ack_log.size(), n);
    endtask

    int n, e0, a0;
    int modes[3] = '{0, 2, 3};

    initial begin
        #1 wb_rst_n = 0;
        repeat (2) step();
        chk("rst_ctl", {s_cyc, m0_ack, m1_ack, m0_err, m1_err}, 0);
        chk("rst_req", {s_adr, s_dat, s_sel, s_we}, 0);
        wb_rst_n = 1;

        // single m0 read
        use_fix[0] = 1; fx_adr[0] = 32'h100; fx_dat[0] = 0; fx_sel[0] = 4'hf; fx_we[0] = 0;
        ram_rdt = 32'hDEADBEEF; smode = 0; req_left[0] = 1;
        step(); chk("single_lat", s_cyc, 0);
        step(); chk("single_cyc", s_cyc, 1); chk("single_adr", s_adr, 32'h100);
        step(); chk("single_ack", {m0_ack, m1_ack}, 2'b10); chk("single_rdt", m0_rdt, 32'hDEADBEEF);
        repeat (3) step();

        // tie after reset: alternate starting at m0, one idle cycle between grants
        do_reset(); clr_logs(); use_fix[0] = 0;
        req_left[0] = 4; req_left[1] = 4;
        wait_acks(8, 40, "tie_cnt");
        for (int i = 0; i < ack_log.size(); i++) begin
            chk("tie_order", ack_log[i], i % 2);
            if (i > 0) chk("tie_gap", ack_t[i] - ack_t[i-1], 3);
        end
        repeat (3) step();

        // debug write while CPU holds cyc
        clr_logs();
        use_fix[1] = 1; fx_adr[1] = 32'h40; fx_dat[1] = 32'h12345678; fx_sel[1] = 4'b0011; fx_we[1] = 1;
        use_fix[0] = 1;
        req_left[1] = 1; step(); req_left[0] = 1;
        wait_acks(2, 20, "dbg_cnt");
        chk("dbg_first", ack_log[0], 1);
        chk("dbg_dat", ack_dat[0], 32'h12345678);
        chk("dbg_sel", {ack_we[0], ack_sel[0]}, 5'b1_0011);
        chk("dbg_cpu", ack_log[1], 0);
        chk("dbg_cpu_req", {ack_we[1], ack_sel[1], ack_dat[1]}, {1'b0, 4'hf, 32'h0});
        use_fix[0] = 0; use_fix[1] = 0;
        repeat (3) step();

        // watchdog expiry in the 16th grant cycle, then m1 takes over
        clr_logs(); smode = 1; e0 = err_n[0];
        req_left[0] = 1;
        wait_scyc("wd_start"); req_left[1] = 1; n = 1;
        while (!m0_err && n < 30) begin step(); n++; end
        chk("wd_cycle", n, TIMEOUT + 1);
        chk("wd_out", {s_cyc, m0_ack, m1_ack}, 0);
        smode = 0;
        wait_acks(1, 10, "wd_next");
        chk("wd_next_m1", ack_log[0], 1);
        chk("wd_err_cnt", err_n[0] - e0, 1);
        repeat (3) step();

        // ack on the expiry cycle wins over err
        smode = 4; req_left[0] = 1;
        wait_scyc("wda_start"); n = 1;
        while (!(m0_ack || m0_err) && n < 30) begin step(); n++; end
        chk("wda_cycle", n, TIMEOUT + 1);
        chk("wda_resp", {m0_ack, m0_err}, 2'b10);
        repeat (3) step();

        // m1 aborts in its second grant cycle, pending m0 follows
        smode = 1; req_left[1] = 1;
        wait_scyc("ab_start");
        abort[1] = 1; req_left[1] = 0; req_left[0] = 1;
        step(); chk("ab_drop", {s_cyc, m1_ack, m1_err, m0_ack}, 0);
        step(); chk("ab_idle", s_cyc, 0);
        step(); chk("ab_m0", {s_cyc, s_adr}, {1'b1, m_adr[0]});
        smode = 0;
        repeat (4) step();

        // async reset mid-grant with ack asserted
        smode = 1; req_left[0] = 1;
        wait_scyc("rm_start"); smode = 5;
        @(posedge wb_clk); #3 wb_rst_n = 0;
        #1 chk("rm_ctl", {s_cyc, m0_ack, m1_ack, m0_err, m1_err}, 0);
        chk("rm_adr", s_adr, 0);
        repeat (2) step();
        wb_rst_n = 1; smode = 0; clr_logs();
        step(); req_left[0] = 1; req_left[1] = 1;
        wait_acks(2, 20, "rm_cnt");
        chk("rm_tie", {ack_log[0][0], ack_log[1][0]}, 2'b01);
        repeat (3) step();

        // randomized traffic
        rnd = 1; a0 = ack_n[0] + ack_n[1]; e0 = err_n[0] + err_n[1];
        req_left[0] = 100000; req_left[1] = 100000;
        for (int b = 0; b < 15; b++) begin
            smode = modes[$urandom_range(0, 2)];
            repeat (200) step();
        end
        req_left[0] = 0; req_left[1] = 0; smode = 2;
        repeat (40) step();
        chk("rnd_acks_seen", (ack_n[0] + ack_n[1]) > a0, 1);
        chk("rnd_errs_seen", (err_n[0] + err_n[1]) > e0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
